// File: rtl/mig_resp_pkg.sv
// Shared encodings and types for the MIG UI responder model.
package mig_resp_pkg;

  localparam logic [2:0] CMD_WRITE  = 3'b000;
  localparam logic [2:0] CMD_READ   = 3'b001;
  localparam int         FIFO_DEPTH = 4;
  // Queue entries hold the address at a fixed width so the struct is not parameterised.
  localparam int         CMD_ADDR_W = 64;

  typedef enum logic {
    ST_CALIB = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  typedef struct packed {
    logic [2:0]            cmd;
    logic [CMD_ADDR_W-1:0] addr;
  } cmd_entry_t;

  function automatic logic is_known_cmd(input logic [2:0] cmd);
    return (cmd == CMD_WRITE) || (cmd == CMD_READ);
  endfunction

endpackage

// File: rtl/mig_resp_fifo.sv
// Four-entry synchronous fall-through FIFO; push while full is allowed when a pop happens the same cycle.
module mig_resp_fifo
  import mig_resp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == CNT_W'(FIFO_DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_dout    = r_mem[r_rptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/mig_ui_responder.sv
// Behavioural MIG user-interface responder: calibration delay, in-order command/data queues, fixed-latency reads.
// Optional build macro MIG_RESP_THROTTLE_EN drops app_rdy one cycle in four while running.
module mig_ui_responder
  import mig_resp_pkg::*;
#(
  parameter int MIG_Data_Port_Size = 128,
  parameter int MIG_Addr_Port_Size = 28,
  parameter int Mem_Depth          = 64,
  parameter int Addr_Step          = 8,
  parameter int Rd_Latency         = 8,
  parameter int Calib_Cycles       = 100
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [MIG_Addr_Port_Size-1:0] app_addr,
  input  logic [2:0]                    app_cmd,
  input  logic                          app_en,
  output logic                          app_rdy,
  input  logic [MIG_Data_Port_Size-1:0] app_wdf_data,
  input  logic                          app_wdf_wren,
  input  logic                          app_wdf_end,
  output logic                          app_wdf_rdy,
  output logic [MIG_Data_Port_Size-1:0] app_rd_data,
  output logic                          app_rd_data_valid,
  output logic                          app_rd_data_end,
  output logic                          init_calib
);

  localparam int DW    = MIG_Data_Port_Size;
  localparam int IDX_W = $clog2(Mem_Depth);
  localparam int CNT_W = $clog2(Calib_Cycles + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_run;
  logic             w_throttle;

  cmd_entry_t       w_cmd_in;
  cmd_entry_t       w_head;
  logic             w_cmd_push, w_cmd_pop, w_cmd_empty, w_cmd_full;
  logic [DW-1:0]    w_wd_head;
  logic             w_wd_push, w_wd_pop, w_wd_empty, w_wd_full;
  logic             w_exec_wr, w_exec_rd;
  logic [IDX_W-1:0] w_idx;

  logic [DW-1:0]         r_mem [Mem_Depth] = '{default: '0};
  logic [Rd_Latency-1:0] r_rd_vld;
  logic [DW-1:0]         r_rd_pipe [Rd_Latency];

  // Every write is a single UI beat, so the end marker carries no information.
  logic w_unused_wdf_end;
  assign w_unused_wdf_end = app_wdf_end;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_CALIB;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_CALIB: begin
        if (r_cnt == CNT_W'(Calib_Cycles - 1)) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_CALIB;
    endcase
  end

  assign w_run      = (r_state == ST_RUN);
  assign init_calib = w_run;

`ifdef MIG_RESP_THROTTLE_EN
  logic [1:0] r_thr;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)   r_thr <= '0;
    else if (w_run) r_thr <= r_thr + 2'd1;
    else            r_thr <= '0;
  end
  assign w_throttle = (r_thr == 2'd3);
`else
  assign w_throttle = 1'b0;
`endif

  assign app_rdy     = w_run & ~w_cmd_full & ~w_throttle;
  assign app_wdf_rdy = w_run & ~w_wd_full;

  // Unknown command codes complete the handshake but never enter the queue.
  assign w_cmd_in.cmd  = app_cmd;
  assign w_cmd_in.addr = CMD_ADDR_W'(app_addr);
  assign w_cmd_push    = app_en & app_rdy & is_known_cmd(app_cmd);
  assign w_wd_push     = app_wdf_wren & app_wdf_rdy;

  mig_resp_fifo #(.WIDTH($bits(cmd_entry_t))) u_cmd_fifo (
    .i_clk   (aclk),
    .i_rst_n (aresetn),
    .i_push  (w_cmd_push),
    .i_din   (w_cmd_in),
    .i_pop   (w_cmd_pop),
    .o_dout  (w_head),
    .o_empty (w_cmd_empty),
    .o_full  (w_cmd_full)
  );

  mig_resp_fifo #(.WIDTH(DW)) u_wd_fifo (
    .i_clk   (aclk),
    .i_rst_n (aresetn),
    .i_push  (w_wd_push),
    .i_din   (app_wdf_data),
    .i_pop   (w_wd_pop),
    .o_dout  (w_wd_head),
    .o_empty (w_wd_empty),
    .o_full  (w_wd_full)
  );

  // Head of the command queue executes at most once per cycle; a write waits for its data.
  assign w_exec_wr = ~w_cmd_empty & (w_head.cmd == CMD_WRITE) & ~w_wd_empty;
  assign w_exec_rd = ~w_cmd_empty & (w_head.cmd == CMD_READ);
  assign w_cmd_pop = w_exec_wr | w_exec_rd;
  assign w_wd_pop  = w_exec_wr;
  assign w_idx     = IDX_W'((w_head.addr / CMD_ADDR_W'(Addr_Step)) % CMD_ADDR_W'(Mem_Depth));

  always_ff @(posedge aclk) begin
    if (w_exec_wr) r_mem[w_idx] <= w_wd_head;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rd_vld <= '0;
    end else begin
      r_rd_vld[0] <= w_exec_rd;
      for (int k = 1; k < Rd_Latency; k++) r_rd_vld[k] <= r_rd_vld[k-1];
    end
  end

  always_ff @(posedge aclk) begin
    r_rd_pipe[0] <= r_mem[w_idx];
    for (int k = 1; k < Rd_Latency; k++) r_rd_pipe[k] <= r_rd_pipe[k-1];
  end

  assign app_rd_data_valid = r_rd_vld[Rd_Latency-1];
  assign app_rd_data_end   = r_rd_vld[Rd_Latency-1];
  assign app_rd_data       = r_rd_vld[Rd_Latency-1] ? r_rd_pipe[Rd_Latency-1] : '0;

endmodule

// File: tb/tb_mig_ui_responder.sv
// Randomised self-checking bench for mig_ui_responder against an in-order memory model.
module tb_mig_ui_responder;

  localparam int DW = 128;
  localparam int AW = 28;
  localparam int MD = 64;
  localparam int AS = 8;
  localparam int RL = 8;
  localparam int CC = 100;
  localparam logic [2:0] C_WR = 3'b000;
  localparam logic [2:0] C_RD = 3'b001;

  logic          aclk, aresetn;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en, app_rdy;
  logic [DW-1:0] app_wdf_data;
  logic          app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid, app_rd_data_end, init_calib;

  mig_ui_responder #(
    .MIG_Data_Port_Size(DW), .MIG_Addr_Port_Size(AW), .Mem_Depth(MD),
    .Addr_Step(AS), .Rd_Latency(RL), .Calib_Cycles(CC)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .app_addr(app_addr), .app_cmd(app_cmd),
    .app_en(app_en), .app_rdy(app_rdy), .app_wdf_data(app_wdf_data),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end), .init_calib(init_calib)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_stuck = 0;
  int n_idle_bad = 0;
  int n_end_bad  = 0;

  typedef struct { bit is_rd; int idx; } op_t;
  op_t           op_q[$];
  logic [DW-1:0] wdata_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] rx_q[$];
  int            rx_cyc_q[$];
  logic [DW-1:0] model_mem [MD];

  always @(posedge aclk) cyc <= cyc + 1;

  always @(negedge aclk) begin
    if (app_rd_data_valid === 1'b1) begin
      rx_q.push_back(app_rd_data);
      rx_cyc_q.push_back(cyc);
      if (app_rd_data_end !== 1'b1) n_end_bad++;
    end else if (app_rd_data !== '0 || app_rd_data_end !== 1'b0) begin
      n_idle_bad++;
    end
  end

  function automatic int idx_of(input logic [AW-1:0] a);
    return int'((longint'(a) / AS) % MD);
  endfunction

  // Commands complete in acceptance order; the k-th write consumes the k-th data word.
  function automatic void model_step();
    while (op_q.size() > 0) begin
      if (!op_q[0].is_rd) begin
        if (wdata_q.size() == 0) break;
        model_mem[op_q[0].idx] = wdata_q.pop_front();
      end else begin
        exp_q.push_back(model_mem[op_q[0].idx]);
      end
      void'(op_q.pop_front());
    end
  endfunction

  task automatic issue(input bit has_c, input logic [2:0] cmd, input logic [AW-1:0] addr,
                       input bit has_d, input logic [DW-1:0] d, output int acc_at);
    bit c_done, d_done, c_acc, d_acc;
    int t;
    c_done = !has_c; d_done = !has_d; t = 0; acc_at = -1;
    while (!(c_done && d_done) && t < 200) begin
      app_en = !c_done; app_cmd = cmd; app_addr = addr;
      app_wdf_wren = !d_done; app_wdf_data = d;
      c_acc = !c_done && app_rdy; d_acc = !d_done && app_wdf_rdy;
      @(negedge aclk);
      if (c_acc) begin
        c_done = 1; acc_at = cyc;
        if (cmd == C_WR) op_q.push_back('{is_rd: 1'b0, idx: idx_of(addr)});
        if (cmd == C_RD) op_q.push_back('{is_rd: 1'b1, idx: idx_of(addr)});
      end
      if (d_acc) begin d_done = 1; wdata_q.push_back(d); end
      model_step();
      t++;
    end
    app_en = 1'b0; app_wdf_wren = 1'b0;
    if (!(c_done && d_done)) n_stuck++;
  endtask

  task automatic drain(output bit ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (op_q.size() == 0 && rx_q.size() >= exp_q.size()) begin ok = 1; break; end
      @(negedge aclk);
    end
    repeat (RL + 3) @(negedge aclk);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    int n, early;
    aresetn = 1'b0; app_en = 0; app_cmd = '0; app_addr = '0;
    app_wdf_wren = 0; app_wdf_end = 0; app_wdf_data = '0;
    repeat (3) @(negedge aclk);
    total++; if (app_rdy !== 1'b0) begin bad++; $display("FAIL rst_app_rdy got=%b want=0", app_rdy); end
    total++; if (app_wdf_rdy !== 1'b0) begin bad++; $display("FAIL rst_wdf_rdy got=%b want=0", app_wdf_rdy); end
    total++; if (app_rd_data_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", app_rd_data_valid); end
    total++; if (app_rd_data_end !== 1'b0) begin bad++; $display("FAIL rst_end got=%b want=0", app_rd_data_end); end
    total++; if (app_rd_data !== '0) begin bad++; $display("FAIL rst_data got=%h want=0", app_rd_data); end
    total++; if (init_calib !== 1'b0) begin bad++; $display("FAIL rst_calib got=%b want=0", init_calib); end
    aresetn = 1'b1;
    n = 0; early = 0;
    while (init_calib !== 1'b1 && n < CC + 50) begin
      @(posedge aclk); #1; n++;
      if (init_calib !== 1'b1 && (app_rdy !== 1'b0 || app_wdf_rdy !== 1'b0)) early++;
    end
    total++; if (n != CC) begin bad++; $display("FAIL calib_cycles got=%0d want=%0d", n, CC); end
    total++; if (early != 0) begin bad++; $display("FAIL rdy_before_calib got=%0d want=0", early); end
    @(negedge aclk);
  endtask

  task automatic test_write_read();
    int a, a_rd, r0, w;
    logic [DW-1:0] pat;
    pat = {16{8'hA5}};
    r0 = rx_q.size();
    issue(1, C_WR, 28'h10, 1, pat, a);
    issue(1, C_RD, 28'h10, 0, '0, a_rd);
    w = 0;
    while (rx_q.size() == r0 && w < RL + 20) begin @(negedge aclk); w++; end
    repeat (RL + 3) @(negedge aclk);
    total++; if (rx_q.size() != r0 + 1) begin bad++; $display("FAIL wr_rd_beats got=%0d want=1", rx_q.size() - r0); end
    if (rx_q.size() > r0) begin
      total++; if (rx_q[r0] !== pat) begin bad++; $display("FAIL wr_rd_data got=%h want=%h", rx_q[r0], pat); end
      total++; if (rx_cyc_q[r0] - a_rd != RL) begin bad++; $display("FAIL rd_latency got=%0d want=%0d", rx_cyc_q[r0] - a_rd, RL); end
    end
    total++; if (n_end_bad != 0) begin bad++; $display("FAIL rd_end got=%0d beats without end want=0", n_end_bad); end
  endtask

  task automatic test_backpressure();
    int a, n, e0;
    bit ok;
    logic [DW-1:0] d [4];
    e0 = exp_q.size();
    for (int i = 0; i < 4; i++) begin
      d[i] = rnd_data();
      issue(1, C_WR, AW'((i + 40) * AS), 0, '0, a);
    end
    repeat (2) begin
      total++; if (app_rdy !== 1'b0) begin bad++; $display("FAIL full_app_rdy got=%b want=0", app_rdy); end
      @(negedge aclk);
    end
    app_wdf_wren = 1'b1; app_wdf_data = d[0];
    total++; if (app_wdf_rdy !== 1'b1) begin bad++; $display("FAIL full_wdf_rdy got=%b want=1", app_wdf_rdy); end
    @(negedge aclk);
    app_wdf_wren = 1'b0; wdata_q.push_back(d[0]); model_step();
    total++; if (app_rdy !== 1'b0) begin bad++; $display("FAIL rdy_during_exec got=%b want=0", app_rdy); end
    n = 0;
    while (app_rdy !== 1'b1 && n < 5) begin @(negedge aclk); n++; end
`ifdef MIG_RESP_THROTTLE_EN
    total++; if (n < 1 || n > 2) begin bad++; $display("FAIL rdy_reassert got=%0d cycles want=1..2", n); end
`else
    total++; if (n != 1) begin bad++; $display("FAIL rdy_reassert got=%0d cycles want=1", n); end
`endif
    for (int i = 1; i < 4; i++) issue(0, C_WR, '0, 1, d[i], a);
    for (int i = 0; i < 4; i++) issue(1, C_RD, AW'((i + 40) * AS), 0, '0, a);
    drain(ok);
    total++; if (!ok || rx_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_count got=%0d want=%0d", rx_q.size(), exp_q.size()); end
    for (int i = e0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++; if (rx_q[i] !== d[i - e0]) begin bad++; $display("FAIL bp_data[%0d] got=%h want=%h", i - e0, rx_q[i], d[i - e0]); end
    end
  endtask

  task automatic test_wrap();
    int a, e0;
    bit ok;
    logic [DW-1:0] d0, d1;
    d0 = rnd_data(); d1 = ~d0;
    e0 = rx_q.size();
    issue(1, C_WR, 28'h0, 1, d0, a);
    issue(1, C_WR, AW'(MD * AS), 1, d1, a);
    issue(1, C_RD, 28'h0, 0, '0, a);
    drain(ok);
    total++; if (!ok || rx_q.size() != e0 + 1) begin bad++; $display("FAIL wrap_count got=%0d want=%0d", rx_q.size() - e0, 1); end
    if (rx_q.size() > e0) begin
      total++; if (rx_q[e0] !== d1) begin bad++; $display("FAIL wrap_data got=%h want=%h", rx_q[e0], d1); end
    end
  endtask

  task automatic test_back_to_back();
    int a, e0;
    bit ok;
    e0 = exp_q.size();
    for (int i = 0; i < 4; i++) issue(1, C_WR, AW'((i + 20) * AS), 1, rnd_data(), a);
    drain(ok);
    e0 = exp_q.size();
    for (int i = 0; i < 4; i++) issue(1, C_RD, AW'((i + 20) * AS), 0, '0, a);
    drain(ok);
    total++; if (!ok || rx_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", rx_q.size(), exp_q.size()); end
    for (int i = e0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", i - e0, rx_q[i], exp_q[i]); end
    end
`ifndef MIG_RESP_THROTTLE_EN
    for (int i = e0 + 1; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++; if (rx_cyc_q[i] - rx_cyc_q[i-1] != 1) begin bad++; $display("FAIL b2b_gap[%0d] got=%0d want=1", i - e0, rx_cyc_q[i] - rx_cyc_q[i-1]); end
    end
`endif
  endtask

  task automatic test_random();
    int a, e0, r;
    bit ok;
    logic [AW-1:0] ad;
    e0 = exp_q.size();
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      ad = ($urandom_range(0, 1) == 1) ? AW'($urandom()) : AW'($urandom_range(0, 2 * MD * AS - 1));
      if (r == 0) issue(1, 3'($urandom_range(2, 7)), ad, 0, '0, a);
      else if (r <= 2) begin
        issue(1, C_WR, ad, 0, '0, a);
        issue(0, C_WR, '0, 1, rnd_data(), a);
      end else if (r <= 5) issue(1, C_WR, ad, 1, rnd_data(), a);
      else issue(1, C_RD, ad, 0, '0, a);
    end
    drain(ok);
    total++; if (!ok || rx_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", rx_q.size(), exp_q.size()); end
    for (int i = e0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_data[%0d] got=%h want=%h", i - e0, rx_q[i], exp_q[i]); end
    end
    total++; if (n_idle_bad != 0) begin bad++; $display("FAIL idle_data got=%0d nonzero idle cycles want=0", n_idle_bad); end
    total++; if (n_stuck != 0) begin bad++; $display("FAIL handshake_timeout got=%0d want=0", n_stuck); end
  endtask

  task automatic test_throttle();
    int lows, first, last, gaps_bad, a, e0;
    bit ok;
    lows = 0; first = -1; last = -1; gaps_bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (app_rdy !== 1'b1) begin
        if (last >= 0 && i - last != 4) gaps_bad++;
        if (first < 0) first = i;
        last = i; lows++;
      end
      @(negedge aclk);
    end
`ifdef MIG_RESP_THROTTLE_EN
    total++; if (lows != 4 || gaps_bad != 0) begin bad++; $display("FAIL throttle_pattern got=%0d lows %0d bad gaps want=4 lows 0 bad gaps", lows, gaps_bad); end
`else
    total++; if (lows != 0) begin bad++; $display("FAIL no_throttle got=%0d lows want=0", lows); end
`endif
    e0 = exp_q.size();
    for (int i = 0; i < 16; i++) begin
      logic [AW-1:0] ad;
      ad = AW'($urandom());
      issue(1, C_WR, ad, 1, rnd_data(), a);
      issue(1, C_RD, ad, 0, '0, a);
    end
    drain(ok);
    total++; if (!ok || rx_q.size() != exp_q.size() || exp_q.size() - e0 != 16) begin bad++; $display("FAIL pairs_count got=%0d want=16", rx_q.size() - e0); end
    for (int i = e0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL pairs_data[%0d] got=%h want=%h", i - e0, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int a, snap, n, e0;
    bit ok;
    for (int i = 0; i < 3; i++) issue(1, C_RD, AW'(i * AS), 0, '0, a);
    @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    op_q.delete(); wdata_q.delete();
    while (exp_q.size() > rx_q.size()) void'(exp_q.pop_back());
    snap = rx_q.size();
    total++; if (app_rdy !== 1'b0 || init_calib !== 1'b0 || app_rd_data_valid !== 1'b0) begin bad++; $display("FAIL midrst_outputs got=%b%b%b want=000", app_rdy, init_calib, app_rd_data_valid); end
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    n = 0;
    while (init_calib !== 1'b1 && n < CC + 50) begin @(posedge aclk); #1; n++; end
    total++; if (n != CC) begin bad++; $display("FAIL recalib_cycles got=%0d want=%0d", n, CC); end
    @(negedge aclk);
    total++; if (rx_q.size() != snap) begin bad++; $display("FAIL stale_reads got=%0d want=0", rx_q.size() - snap); end
    e0 = exp_q.size();
    issue(1, C_RD, 28'h10, 0, '0, a);
    drain(ok);
    total++; if (!ok || rx_q.size() != e0 + 1) begin bad++; $display("FAIL retain_count got=%0d want=1", rx_q.size() - e0); end
    if (rx_q.size() > e0 && exp_q.size() > e0) begin
      total++; if (rx_q[e0] !== exp_q[e0]) begin bad++; $display("FAIL retain_data got=%h want=%h", rx_q[e0], exp_q[e0]); end
    end
  endtask

  initial begin
    aresetn = 1'b0;
    for (int i = 0; i < MD; i++) model_mem[i] = '0;
    @(negedge aclk);
    test_reset();
    test_write_read();
    test_backpressure();
    test_wrap();
    test_back_to_back();
    test_random();
    test_throttle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mig_ui_responder.md
MIG_UI_RESPONDER -- requirements
Module: mig_ui_responder

Interface
REQ-001 SHALL have parameter MIG_Data_Port_Size, default 128: app data width in bits.
REQ-002 SHALL have parameter MIG_Addr_Port_Size, default 28: app address width in bits.
REQ-003 SHALL have parameter Mem_Depth, default 64: number of stored UI words, power of two.
REQ-004 SHALL have parameter Addr_Step, default 8: app_addr increment per UI word.
REQ-005 SHALL have parameter Rd_Latency, default 8: read execute-to-data cycles, at least 1.
REQ-006 SHALL have parameter Calib_Cycles, default 100: cycles from reset release to init_calib.
REQ-007 SHALL have ports aclk (in, 1) and aresetn (in, 1): one clock; reset is asynchronous and active-low.
REQ-008 SHALL have ports app_addr (in, MIG_Addr_Port_Size), app_cmd (in, 3), app_en (in, 1) and app_rdy (out, 1): command channel.
REQ-009 SHALL have ports app_wdf_data (in, MIG_Data_Port_Size), app_wdf_wren (in, 1), app_wdf_end (in, 1) and app_wdf_rdy (out, 1): write data channel.
REQ-010 SHALL have ports app_rd_data (out, MIG_Data_Port_Size), app_rd_data_valid (out, 1) and app_rd_data_end (out, 1): read return channel.
REQ-011 SHALL have port init_calib (out, 1): calibration done.

Function
REQ-012 SHALL implement state machine CALIB -> RUN; CALIB counts Calib_Cycles, then RUN; init_calib=1 only in RUN.
REQ-013 SHALL accept a command only when app_en&app_rdy; app_cmd 3'b000=write, 3'b001=read; other codes accepted and discarded.
REQ-014 SHALL queue accepted commands {cmd, addr} in a 4-entry in-order command FIFO.
REQ-015 SHALL drive app_rdy = RUN & command FIFO not full.
REQ-016 SHALL push app_wdf_data into a 4-entry write-data FIFO when app_wdf_wren&app_wdf_rdy; app_wdf_end is ignored (single UI beat per burst).
REQ-017 SHALL drive app_wdf_rdy = RUN & write-data FIFO not full; write data may arrive before, with, or after its command.
REQ-018 SHALL compute word index = (addr / Addr_Step) mod Mem_Depth; upper address bits wrap.
REQ-019 SHALL execute a head write only when the write-data FIFO is non-empty: pop both FIFOs, store the data at the index; otherwise stall the head.
REQ-020 SHALL execute a head read unconditionally: pop it, read the memory and deliver the word exactly Rd_Latency cycles later with app_rd_data_valid=1 and app_rd_data_end=1 for one cycle.
REQ-021 SHALL execute at most one command per cycle, strictly in acceptance order, so a read returns every earlier-accepted write to the same index.
REQ-022 SHALL allow push and pop of the same FIFO in one cycle, including while full.
REQ-023 SHALL return reads back-to-back (one per cycle) when reads are queued consecutively; app_rd_data is 0 when not valid.
REQ-024 SHALL apply no backpressure on the read return; reads are never dropped.

Reset
REQ-025 SHALL, while aresetn=0, force app_rdy=0, app_wdf_rdy=0, app_rd_data_valid=0, app_rd_data_end=0, app_rd_data=0, init_calib=0, state=CALIB, counter=0, both FIFOs empty, read pipeline empty.
REQ-026 SHALL discard all queued commands, data and in-flight reads on reset mid-operation and rerun CALIB.
REQ-027 SHALL leave memory contents unchanged by reset; memory is zero only at time 0.

Configuration
REQ-028 SHALL, with macro MIG_RESP_THROTTLE_EN defined, run a free 2-bit counter in RUN and force app_rdy=0 whenever it equals 3 (one cycle in four).
REQ-029 SHALL, without MIG_RESP_THROTTLE_EN, apply no throttling; app_rdy follows REQ-015 only.

Structure
REQ-030 SHALL place the command encodings (CMD_WRITE=3'b000, CMD_READ=3'b001), the state enum and the queue entry struct in package mig_resp_pkg.
REQ-031 SHALL instantiate sub-module mig_resp_fifo (synchronous, parameterised width, depth 4) once for commands and once for write data.

Verification
REQ-032 SHALL check: reset release -> init_calib rises exactly Calib_Cycles cycles later; app_rdy and app_wdf_rdy stay 0 before that.
REQ-033 SHALL check: write addr 0x10 data 0xA5..A5, then read addr 0x10 -> one valid beat of 0xA5..A5 with app_rd_data_end=1, Rd_Latency cycles after read execute.
REQ-034 SHALL check: four write commands with no data -> app_rdy=0 on the fifth; supplying one data word re-asserts app_rdy the next cycle.
REQ-035 SHALL check: write addr 0 then addr Mem_Depth*Addr_Step with distinct data, read addr 0 -> second data word returned (wrap).
REQ-036 SHALL check: 3 reads queued, aresetn pulsed low mid-pipeline -> no app_rd_data_valid after reset; init_calib re-rises after Calib_Cycles.
REQ-037 SHALL check: with MIG_RESP_THROTTLE_EN, continuous app_en -> app_rdy low exactly every 4th RUN cycle, and all 16 write/read pairs return correct data.
